inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/icepic_lib_pkg.sv | 32 +++
 rtl/call_stack.sv | 32 +++
 rtl/inst_fetch.sv | 106 ++++++++++
 tb/tb_inst_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/icepic_lib_pkg.sv
// Shared types and constants for the icepic core.
package icepic_lib_pkg;

  localparam int unsigned INST_W      = 12;
  localparam int unsigned JUMP_ADDR_W = 11;

  typedef logic [INST_W-1:0] inst_t;

  // All-zero word decodes as NOP; used for every substituted slot.
  localparam inst_t NOP = 12'h000;

  // Next-PC source chosen by the decoder for the instruction on inst_out.
  typedef enum logic [1:0] {
    PC_NEXT,
    PC_JUMP,
    PC_RET,
    PC_SKIP
  } pc_update_sel_t;

  typedef enum logic [1:0] {
    StFill,
    StRun,
    StFlush
  } fetch_state_e;

  // Computed-goto target: page bits sit above a forced-zero bit 8.
  function automatic logic [JUMP_ADDR_W-1:0] pcl_target(input logic [1:0] page,
                                                        input logic [7:0] pcl);
    return {page, 1'b0, pcl};
  endfunction

endpackage

// File: rtl/call_stack.sv
// Two-entry return-address stack. Overflow drops the bottom entry; underflow
// keeps returning the bottom entry.
module call_stack #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] data_in,
  output logic [Width-1:0] top_out
);

  logic [Width-1:0] top_q;
  logic [Width-1:0] bottom_q;

  // Push shifts top into bottom; pop copies bottom up and leaves bottom alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q    <= '0;
      bottom_q <= '0;
    end else if (push) begin
      top_q    <= data_in;
      bottom_q <= top_q;
    end else if (pop) begin
      top_q    <= bottom_q;
    end
  end

  assign top_out = top_q;

endmodule

// File: rtl/inst_fetch.sv
// Two-stage instruction fetch: address registered to a synchronous ROM, the
// returned word is presented to the decoder one cycle later. Redirects cost
// one NOP slot.
module inst_fetch
  import icepic_lib_pkg::*;
#(
  parameter int unsigned           PROG_ADDR_W  = 10,
  parameter logic [PROG_ADDR_W-1:0] RESET_VECTOR = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  pc_update_sel_t         pc_update_sel_in,
  input  logic [JUMP_ADDR_W-1:0] jump_addr_in,
  input  logic                   stack_push_in,
  input  logic                   stack_pop_in,
  input  logic                   skip_cond_in,
  input  logic                   pcl_write_en_in,
  input  logic [7:0]             pcl_data_in,
  input  logic [1:0]             page_in,
  output logic [PROG_ADDR_W-1:0] rom_addr_out,
  input  logic [INST_W-1:0]      rom_data_in,
  output inst_t                  inst_out,
  output logic [PROG_ADDR_W-1:0] pc_out,
  output logic                   flush_out
);

  fetch_state_e state_q, state_d;
  logic [PROG_ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [PROG_ADDR_W-1:0] pc_q;
  logic [PROG_ADDR_W-1:0] addr_inc;
  logic [PROG_ADDR_W-1:0] ret_addr;
  logic [PROG_ADDR_W-1:0] stack_top;
  logic                   redirect;
  logic                   stack_push;
  logic                   stack_pop;

  assign addr_inc = rom_addr_q + PROG_ADDR_W'(1);
  assign ret_addr = pc_q + PROG_ADDR_W'(1);

  // State, fetch address and the address of the word now on inst_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      rom_addr_q <= RESET_VECTOR;
      pc_q       <= RESET_VECTOR;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      pc_q       <= rom_addr_q;
    end
  end

  // Next fetch address and state; control inputs only count for real slots.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = addr_inc;
    redirect   = 1'b0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    unique case (state_q)
      StFill, StFlush: state_d = StRun;
      StRun: begin
        stack_push = stack_push_in;
        stack_pop  = stack_pop_in & ~stack_push_in;
        if (pcl_write_en_in) begin
          redirect   = 1'b1;
          rom_addr_d = PROG_ADDR_W'(pcl_target(page_in, pcl_data_in));
        end else begin
          unique case (pc_update_sel_in)
            PC_JUMP: begin
              redirect   = 1'b1;
              rom_addr_d = PROG_ADDR_W'(jump_addr_in);
            end
            PC_RET: begin
              redirect   = 1'b1;
              rom_addr_d = stack_top;
            end
            // Taken skip lands on the same address as a plain increment, but
            // the already-fetched word must still be squashed.
            PC_SKIP: redirect = skip_cond_in;
            default: redirect = 1'b0;
          endcase
        end
        if (redirect) state_d = StFlush;
      end
      default: state_d = StFill;
    endcase
  end

  call_stack #(
    .Width (PROG_ADDR_W)
  ) u_call_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (stack_push),
    .pop     (stack_pop),
    .data_in (ret_addr),
    .top_out (stack_top)
  );

  assign rom_addr_out = rom_addr_q;
  assign pc_out       = pc_q;
  assign flush_out    = (state_q != StRun);
  assign inst_out     = (state_q == StRun) ? inst_t'(rom_data_in) : NOP;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run against an
// address-sequence reference model.
module tb_inst_fetch;
  import icepic_lib_pkg::*;

  logic           clk;
  logic           rst_n;
  pc_update_sel_t sel;
  logic [10:0]    jump_addr;
  logic           push, pop, skip, pcl_en;
  logic [7:0]     pcl_data;
  logic [1:0]     page;
  logic [9:0]     rom_addr;
  logic [11:0]    rom_data;
  inst_t          inst;
  logic [9:0]     pc;
  logic           flush;

  logic [11:0] rom [1024];
  int checks = 0;
  int errors = 0;

  inst_fetch #(
    .PROG_ADDR_W  (10),
    .RESET_VECTOR (10'h3FF)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_update_sel_in (sel),
    .jump_addr_in     (jump_addr),
    .stack_push_in    (push),
    .stack_pop_in     (pop),
    .skip_cond_in     (skip),
    .pcl_write_en_in  (pcl_en),
    .pcl_data_in      (pcl_data),
    .page_in          (page),
    .rom_addr_out     (rom_addr),
    .rom_data_in      (rom_data),
    .inst_out         (inst),
    .pc_out           (pc),
    .flush_out        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program ROM, one cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic clear_ctl();
    sel = PC_NEXT; jump_addr = '0; push = 0; pop = 0; skip = 0;
    pcl_en = 0; pcl_data = '0; page = '0;
  endtask

  // From a RUN negedge, jump to a and stop at the negedge where pc_out == a.
  task automatic goto_addr(input logic [9:0] a);
    sel = PC_JUMP; jump_addr = {1'b0, a};
    @(negedge clk); clear_ctl();
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_ctl();
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (rom_addr !== 10'h3FF) begin errors++; $display("FAIL rst_rom_addr: got %h want 3ff", rom_addr); end
    checks++; if (pc !== 10'h3FF) begin errors++; $display("FAIL rst_pc: got %h want 3ff", pc); end
    checks++; if (inst !== 12'h000 || flush !== 1'b1) begin errors++; $display("FAIL rst_nop: got inst %h flush %b want 000 1", inst, flush); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL fill_rom_addr1: got %h want 000", rom_addr); end
    checks++; if (inst !== rom[10'h3FF] || flush !== 1'b0 || pc !== 10'h3FF) begin errors++; $display("FAIL first_inst: got %h/%b/%h want %h/0/3ff", inst, flush, pc, rom[10'h3FF]); end
    @(negedge clk);
    checks++; if (rom_addr !== 10'h001) begin errors++; $display("FAIL fill_rom_addr2: got %h want 001", rom_addr); end
    checks++; if (inst !== rom[10'h000] || pc !== 10'h000) begin errors++; $display("FAIL wrap_inst: got %h pc %h want %h pc 000", inst, pc, rom[10'h000]); end
    // Return straight after reset pops the cleared stack: lands on 000.
    sel = PC_RET; pop = 1;
    @(negedge clk); clear_ctl();
    @(negedge clk);
    checks++; if (pc !== 10'h000 || flush !== 1'b0) begin errors++; $display("FAIL rst_stack: got pc %h flush %b want 000 0", pc, flush); end
  endtask

  task automatic test_goto();
    goto_addr(10'h010);
    sel = PC_JUMP; jump_addr = 11'h155;
    @(negedge clk); clear_ctl();
    checks++; if (inst !== 12'h000 || flush !== 1'b1 || pc !== 10'h011) begin errors++; $display("FAIL goto_nop: got %h/%b/%h want 000/1/011", inst, flush, pc); end
    @(negedge clk);
    checks++; if (inst !== rom[10'h155] || flush !== 1'b0 || pc !== 10'h155) begin errors++; $display("FAIL goto_target: got %h/%b/%h want %h/0/155", inst, flush, pc, rom[10'h155]); end
  endtask

  task automatic test_call_ret();
    goto_addr(10'h005);
    sel = PC_JUMP; jump_addr = 11'h020; push = 1;
    @(negedge clk); clear_ctl();
    @(negedge clk);
    checks++; if (pc !== 10'h020) begin errors++; $display("FAIL call_target: got %h want 020", pc); end
    sel = PC_RET; pop = 1;
    @(negedge clk); clear_ctl();
    @(negedge clk);
    checks++; if (pc !== 10'h006 || inst !== rom[10'h006]) begin errors++; $display("FAIL ret_addr: got %h want 006", pc); end
  endtask

  task automatic test_nested();
    logic [9:0] want [3];
    want[0] = 10'h202; want[1] = 10'h102; want[2] = 10'h102;
    goto_addr(10'h001);
    for (int i = 1; i <= 3; i++) begin
      sel = PC_JUMP; jump_addr = 11'(i * 256 + 1); push = 1;
      @(negedge clk); clear_ctl();
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      sel = PC_RET; pop = 1;
      @(negedge clk); clear_ctl();
      @(negedge clk);
      checks++; if (pc !== want[i]) begin errors++; $display("FAIL nested_ret%0d: got %h want %h", i, pc, want[i]); end
    end
  endtask

  task automatic test_skip();
    goto_addr(10'h040);
    sel = PC_SKIP; skip = 1;
    @(negedge clk); clear_ctl();
    checks++; if (inst !== 12'h000 || flush !== 1'b1 || pc !== 10'h041) begin errors++; $display("FAIL skip_nop: got %h/%b/%h want 000/1/041", inst, flush, pc); end
    @(negedge clk);
    checks++; if (inst !== rom[10'h042] || pc !== 10'h042) begin errors++; $display("FAIL skip_after: got %h pc %h want %h pc 042", inst, pc, rom[10'h042]); end
    goto_addr(10'h040);
    sel = PC_SKIP; skip = 0;
    @(negedge clk); clear_ctl();
    checks++; if (inst !== rom[10'h041] || flush !== 1'b0 || pc !== 10'h041) begin errors++; $display("FAIL noskip: got %h/%b/%h want %h/0/041", inst, flush, pc, rom[10'h041]); end
  endtask

  task automatic test_pcl_reset();
    goto_addr(10'h030);
    // PCL write outranks a simultaneous jump.
    pcl_en = 1; pcl_data = 8'hAB; page = 2'b01; sel = PC_JUMP; jump_addr = 11'h111;
    @(negedge clk); clear_ctl();
    checks++; if (flush !== 1'b1 || rom_addr !== 10'h2AB) begin errors++; $display("FAIL pcl_fetch: got flush %b addr %h want 1 2ab", flush, rom_addr); end
    @(negedge clk);
    checks++; if (pc !== 10'h2AB || inst !== rom[10'h2AB]) begin errors++; $display("FAIL pcl_target: got %h want 2ab", pc); end
    pcl_en = 1; pcl_data = 8'hAB; page = 2'b01;
    @(negedge clk); clear_ctl();
    rst_n = 0;
    #1;
    checks++; if (rom_addr !== 10'h3FF || pc !== 10'h3FF || flush !== 1'b1) begin errors++; $display("FAIL pcl_rst: got addr %h pc %h flush %b want 3ff 3ff 1", rom_addr, pc, flush); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    checks++; if (pc !== 10'h3FF || inst !== rom[10'h3FF] || rom_addr !== 10'h000) begin errors++; $display("FAIL pcl_rst_resume: got pc %h addr %h want 3ff 000", pc, rom_addr); end
  endtask

  // Randomized run: model tracks the address sequence, slot validity and stack.
  task automatic test_random();
    logic [9:0]  m_pc, m_next, target;
    logic [9:0]  m_stack [2];
    logic        m_valid, redir;
    logic [10:0] pcl_full;
    logic [11:0] exp_inst;
    int          cyc_errs;
    cyc_errs = 0;
    clear_ctl();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    m_pc = 10'h3FF; m_next = 10'h3FF; m_valid = 0; m_stack[0] = '0; m_stack[1] = '0;
    for (int c = 0; c < 600; c++) begin
      exp_inst = m_valid ? rom[m_pc] : 12'h000;
      checks++;
      if (pc !== m_pc || flush !== !m_valid || inst !== exp_inst || rom_addr !== m_next) begin
        errors++; cyc_errs++;
        if (cyc_errs < 10)
          $display("FAIL rand_c%0d: got pc %h fl %b inst %h addr %h want pc %h fl %b inst %h addr %h",
                   c, pc, flush, inst, rom_addr, m_pc, !m_valid, exp_inst, m_next);
      end
      sel = pc_update_sel_t'($urandom_range(0, 3));
      jump_addr = 11'($urandom);
      push = ($urandom_range(0, 3) == 0);
      pop = ($urandom_range(0, 2) == 0);
      skip = $urandom_range(0, 1) == 1;
      pcl_en = ($urandom_range(0, 7) == 0);
      pcl_data = 8'($urandom);
      page = 2'($urandom);
      if (m_valid) begin
        pcl_full = {page, 1'b0, pcl_data};
        redir = 1'b1;
        if (pcl_en) target = pcl_full[9:0];
        else if (sel == PC_JUMP) target = jump_addr[9:0];
        else if (sel == PC_RET) target = m_stack[0];
        else begin target = m_next + 10'd1; redir = (sel == PC_SKIP) && skip; end
        if (push) begin m_stack[1] = m_stack[0]; m_stack[0] = m_pc + 10'd1; end
        else if (pop) m_stack[0] = m_stack[1];
        m_pc = m_next; m_valid = !redir; m_next = target;
      end else begin
        m_pc = m_next; m_valid = 1'b1; m_next = m_next + 10'd1;
      end
      @(negedge clk);
    end
    clear_ctl();
  endtask

  initial begin
    rst_n = 1;
    clear_ctl();
    for (int i = 0; i < 1024; i++) rom[i] = 12'($urandom);
    test_reset();
    test_goto();
    test_call_ret();
    test_nested();
    test_skip();
    test_pcl_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
